adpll_gain_scheduler: RTL and testbench
=======================================

ADPLL_GAIN_SCHEDULER -- requirements
Module: adpll_gain_scheduler

Interface
REQ-001 Parameter PDET_WIDTH, default 8: width of the signed phase error input.
REQ-002 Parameter KP_WIDTH, default 3: width of the proportional gain output.
REQ-003 Parameter KI_WIDTH, default 4: width of the integral gain output.
REQ-004 Parameter LOCK_THRESH, default 8'd4: in-window limit on |error|, inclusive.
REQ-005 Parameter UNLOCK_THRESH, default 8'd16: out-of-window limit; |error| > UNLOCK_THRESH counts as a bad sample.
REQ-006 Parameter LOCK_COUNT, default 16: consecutive good samples required to advance a gear.
REQ-007 Parameter UNLOCK_COUNT, default 4: consecutive bad samples required to declare loss of lock.
REQ-008 Parameters KP_ACQ/KI_ACQ, default 3'b110/4'b0100: gains in ACQUIRE.
REQ-009 Parameters KP_TRK/KI_TRK, default 3'b010/4'b0010: gains in TRACK.
REQ-010 Parameters KP_LCK/KI_LCK, default 3'b001/4'b0001: gains in LOCKED.
REQ-011 fpga_clk_i  in  1  system clock; the only clock in the block.
REQ-012 reset_i  in  1  asynchronous, active-low reset.
REQ-013 start_i  in  1  level; 1 = run the loop, 0 = return to IDLE.
REQ-014 sample_i  in  1  divided generated clock (gen_div8), asynchronous to fpga_clk_i.
REQ-015 error_i  in  PDET_WIDTH  signed combined phase error, two's complement.
REQ-016 pll_enable_o  out  1  enable for the phase accumulator.
REQ-017 kp_o  out  KP_WIDTH  proportional gain to the loop filter.
REQ-018 ki_o  out  KI_WIDTH  integral gain to the loop filter.
REQ-019 state_o  out  2  current state: IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3.
REQ-020 locked_o  out  1  high while in LOCKED.
REQ-021 lock_lost_o  out  1  one-cycle pulse on the LOCKED->ACQUIRE transition.

Function
REQ-022 sample_i SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL produce a one-cycle sample strobe 3 fpga_clk_i cycles after sample_i rises.
REQ-023 error_i SHALL be captured only in strobe cycles; |error| SHALL saturate, so -2^(PDET_WIDTH-1) maps to 2^(PDET_WIDTH-1)-1.
REQ-024 IDLE: pll_enable_o=0 and counters held at 0; start_i=1 -> ACQUIRE on the next edge.
REQ-025 ACQUIRE/TRACK: a strobe with |err| <= LOCK_THRESH increments good_cnt; any other strobe clears it; good_cnt reaching LOCK_COUNT -> next gear (ACQUIRE->TRACK, TRACK->LOCKED) with good_cnt cleared.
REQ-026 LOCKED: a strobe with |err| > UNLOCK_THRESH increments bad_cnt; any other strobe clears it; bad_cnt reaching UNLOCK_COUNT -> ACQUIRE, pulse lock_lost_o, clear both counters.
REQ-027 In any non-IDLE state, start_i=0 -> IDLE on the next edge; this SHALL take priority over a simultaneous gear transition.
REQ-028 Counters SHALL saturate and never wrap; width SHALL be sized by $clog2 of the larger of LOCK_COUNT and UNLOCK_COUNT, plus 1.
REQ-029 kp_o/ki_o SHALL be registered and decoded from the next state so they change on the same edge as state_o; IDLE SHALL drive the ACQ gains.
REQ-030 pll_enable_o SHALL be 1 in every state except IDLE.

Reset
REQ-031 reset_i low SHALL asynchronously force IDLE, counters and synchronizer flops 0, pll_enable_o=0, locked_o=0, lock_lost_o=0, kp_o=KP_ACQ, ki_o=KI_ACQ.
REQ-032 Assertion of reset_i mid-operation SHALL abort any count; a strobe pending in the synchronizer SHALL be discarded.

Structure
REQ-033 The state encoding and default gain constants SHALL live in a shared package, adpll_pkg.
REQ-034 The synchronizer and edge detector SHALL be a sub-module, sync_edge_detect, reusable for the phase detectors.

Verification
REQ-035 Reset release, start_i=1, 16 strobes with error=+3 -> state_o goes 0->1->2, and kp_o=3'b010 after the 16th strobe.
REQ-036 In TRACK: 15 good strobes, one with error=+5, then 16 good -> LOCKED only after the final 16, locked_o=1, kp_o=3'b001, ki_o=4'b0001.
REQ-037 In LOCKED: 4 strobes with error=-17 -> ACQUIRE, one-cycle lock_lost_o pulse, kp_o=3'b110; 3 bad strobes then error=16 -> stays LOCKED.
REQ-038 error=8'h80 -> treated as |err|=127 (bad); no overflow into the good window.
REQ-039 start_i dropped in the same cycle as the 16th good strobe in TRACK -> IDLE, not LOCKED; pll_enable_o=0.
REQ-040 reset_i pulsed low asynchronously (between clock edges) while in LOCKED -> all outputs at reset values immediately; restart requires a new full ACQUIRE sequence.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared state encoding and default loop-gain constants for the ADPLL control
// blocks (gain scheduler, phase detectors).
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    localparam int          LOCK_THRESH_DEF   = 4;
    localparam int          UNLOCK_THRESH_DEF = 16;
    localparam int          LOCK_COUNT_DEF    = 16;
    localparam int          UNLOCK_COUNT_DEF  = 4;

    localparam logic [2:0]  KP_ACQ_DEF = 3'b110;
    localparam logic [3:0]  KI_ACQ_DEF = 4'b0100;
    localparam logic [2:0]  KP_TRK_DEF = 3'b010;
    localparam logic [3:0]  KI_TRK_DEF = 4'b0010;
    localparam logic [2:0]  KP_LCK_DEF = 3'b001;
    localparam logic [3:0]  KI_LCK_DEF = 4'b0001;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level plus a registered
// single-cycle rising-edge strobe in the destination clock domain.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_d = sync_q & ~prev_q;
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/adpll_gain_scheduler.sv
// Gear-shifting gain scheduler: walks IDLE -> ACQUIRE -> TRACK -> LOCKED on
// runs of small phase error and drops back to ACQUIRE on a run of large error.
module adpll_gain_scheduler
    import adpll_pkg::*;
#(
    parameter int                     PDET_WIDTH    = 8,
    parameter int                     KP_WIDTH      = 3,
    parameter int                     KI_WIDTH      = 4,
    parameter logic [PDET_WIDTH-1:0]  LOCK_THRESH   = PDET_WIDTH'(LOCK_THRESH_DEF),
    parameter logic [PDET_WIDTH-1:0]  UNLOCK_THRESH = PDET_WIDTH'(UNLOCK_THRESH_DEF),
    parameter int                     LOCK_COUNT    = LOCK_COUNT_DEF,
    parameter int                     UNLOCK_COUNT  = UNLOCK_COUNT_DEF,
    parameter logic [KP_WIDTH-1:0]    KP_ACQ        = KP_WIDTH'(KP_ACQ_DEF),
    parameter logic [KI_WIDTH-1:0]    KI_ACQ        = KI_WIDTH'(KI_ACQ_DEF),
    parameter logic [KP_WIDTH-1:0]    KP_TRK        = KP_WIDTH'(KP_TRK_DEF),
    parameter logic [KI_WIDTH-1:0]    KI_TRK        = KI_WIDTH'(KI_TRK_DEF),
    parameter logic [KP_WIDTH-1:0]    KP_LCK        = KP_WIDTH'(KP_LCK_DEF),
    parameter logic [KI_WIDTH-1:0]    KI_LCK        = KI_WIDTH'(KI_LCK_DEF)
) (
    input  logic                         fpga_clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic                         sample_i,
    input  logic signed [PDET_WIDTH-1:0] error_i,
    output logic                         pll_enable_o,
    output logic [KP_WIDTH-1:0]          kp_o,
    output logic [KI_WIDTH-1:0]          ki_o,
    output logic [1:0]                   state_o,
    output logic                         locked_o,
    output logic                         lock_lost_o
);

    localparam int               CNT_W        = $clog2(max_int(LOCK_COUNT, UNLOCK_COUNT)) + 1;
    localparam logic [CNT_W-1:0] LOCK_CNT_V   = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] UNLOCK_CNT_V = CNT_W'(UNLOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    logic strobe;

    sync_edge_detect u_sample_sync (
        .clk     (fpga_clk_i),
        .rst_n   (reset_i),
        .async_i (sample_i),
        .rise_o  (strobe)
    );

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      good_q, good_d;
    logic [CNT_W-1:0]      bad_q, bad_d;
    logic                  lost_q, lost_d;
    logic                  en_q, en_d;
    logic                  locked_q, locked_d;
    logic [KP_WIDTH-1:0]   kp_q, kp_d;
    logic [KI_WIDTH-1:0]   ki_q, ki_d;

    logic [PDET_WIDTH-1:0] err_mag;
    logic                  err_good;
    logic                  err_bad;
    logic [CNT_W-1:0]      good_inc;
    logic [CNT_W-1:0]      bad_inc;

    // The most negative code has no positive twin; clamp it to the largest magnitude.
    always_comb begin
        err_mag = error_i;
        if (error_i[PDET_WIDTH-1]) begin
            if (error_i[PDET_WIDTH-2:0] == '0) begin
                err_mag = {1'b0, {(PDET_WIDTH-1){1'b1}}};
            end else begin
                err_mag = -error_i;
            end
        end
    end

    assign err_good = (err_mag <= LOCK_THRESH);
    assign err_bad  = (err_mag >  UNLOCK_THRESH);
    assign good_inc = (good_q == CNT_MAX) ? good_q : good_q + 1'b1;
    assign bad_inc  = (bad_q  == CNT_MAX) ? bad_q  : bad_q  + 1'b1;

    // NOTE: every variable driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        lost_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                good_d = '0;
                bad_d  = '0;
                if (start_i) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE, ST_TRACK: begin
                if (strobe) begin
                    if (!err_good) begin
                        good_d = '0;
                    end else if (good_inc >= LOCK_CNT_V) begin
                        state_d = (state_q == ST_ACQUIRE) ? ST_TRACK : ST_LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end
            end
            ST_LOCKED: begin
                if (strobe) begin
                    if (!err_bad) begin
                        bad_d = '0;
                    end else if (bad_inc >= UNLOCK_CNT_V) begin
                        state_d = ST_ACQUIRE;
                        good_d  = '0;
                        bad_d   = '0;
                        lost_d  = 1'b1;
                    end else begin
                        bad_d = bad_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping start_i overrides any gear change decided above.
        if (state_q != ST_IDLE && !start_i) begin
            state_d = ST_IDLE;
            good_d  = '0;
            bad_d   = '0;
            lost_d  = 1'b0;
        end
    end

    always_comb begin
        en_d     = (state_d != ST_IDLE);
        locked_d = (state_d == ST_LOCKED);
        kp_d     = KP_ACQ;
        ki_d     = KI_ACQ;
        case (state_d)
            ST_TRACK: begin
                kp_d = KP_TRK;
                ki_d = KI_TRK;
            end
            ST_LOCKED: begin
                kp_d = KP_LCK;
                ki_d = KI_LCK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            good_q   <= '0;
            bad_q    <= '0;
            lost_q   <= 1'b0;
            en_q     <= 1'b0;
            locked_q <= 1'b0;
            kp_q     <= KP_ACQ;
            ki_q     <= KI_ACQ;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            lost_q   <= lost_d;
            en_q     <= en_d;
            locked_q <= locked_d;
            kp_q     <= kp_d;
            ki_q     <= ki_d;
        end
    end

    assign state_o      = state_q;
    assign pll_enable_o = en_q;
    assign locked_o     = locked_q;
    assign lock_lost_o  = lost_q;
    assign kp_o         = kp_q;
    assign ki_o         = ki_q;

endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// Scoreboard bench for adpll_gain_scheduler: expected output bundles are queued
// by the stimulus and popped by a monitor on every observed output change.
module tb_adpll_gain_scheduler;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] kp;
        logic [3:0] ki;
        logic       lk;
        logic       en;
        logic       ll;
    } obs_t;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              start_i = 1'b0;
    logic              sample_i = 1'b0;
    logic signed [7:0] error_i = '0;
    logic              pll_enable_o;
    logic [2:0]        kp_o;
    logic [3:0]        ki_o;
    logic [1:0]        state_o;
    logic              locked_o;
    logic              lock_lost_o;

    int   n_vec = 0;
    int   n_bad = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    adpll_gain_scheduler dut (
        .fpga_clk_i   (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .sample_i     (sample_i),
        .error_i      (error_i),
        .pll_enable_o (pll_enable_o),
        .kp_o         (kp_o),
        .ki_o         (ki_o),
        .state_o      (state_o),
        .locked_o     (locked_o),
        .lock_lost_o  (lock_lost_o)
    );

    // Expected bundle for a state; gains from the default parameter table.
    function automatic obs_t mk(input logic [1:0] st, input logic en, input logic ll);
        obs_t o;
        o.st = st;
        o.en = en;
        o.ll = ll;
        o.lk = (st == 2'd3);
        case (st)
            2'd2:    begin o.kp = 3'b010; o.ki = 4'b0010; end
            2'd3:    begin o.kp = 3'b001; o.ki = 4'b0001; end
            default: begin o.kp = 3'b110; o.ki = 4'b0100; end
        endcase
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st = state_o;
        o.kp = kp_o;
        o.ki = ki_o;
        o.lk = locked_o;
        o.en = pll_enable_o;
        o.ll = lock_lost_o;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: every change in the output bundle must match the next queued entry.
    initial begin
        obs_t prev;
        obs_t cur;
        obs_t e;
        prev = mk(2'd0, 1'b0, 1'b0);
        forever begin
            @(negedge clk);
            cur = observe();
            if (cur !== prev) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got=%h expected=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_bad++;
                        $display("FAIL output_bundle: got=%h expected=%h", cur, e);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: got=%0d pending expected=0 pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One sample_i period; drop_start lowers start_i in the strobe cycle.
    task automatic do_strobe(input logic signed [7:0] e, input bit drop_start);
        @(posedge clk);
        #2;
        error_i  = e;
        sample_i = 1'b1;
        repeat (3) @(posedge clk);
        if (drop_start) begin
            #2;
            start_i = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2;
        sample_i = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic run(input int n, input logic signed [7:0] e);
        for (int i = 0; i < n; i++) do_strobe(e, 1'b0);
    endtask

    task automatic check_state(input string name, input logic [1:0] st);
        #1;
        check(name, {30'd0, state_o}, {30'd0, st});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},  {30'd0, state_o},     32'd0);
        check({tag, "_enable"}, {31'd0, pll_enable_o}, 32'd0);
        check({tag, "_locked"}, {31'd0, locked_o},    32'd0);
        check({tag, "_lost"},   {31'd0, lock_lost_o}, 32'd0);
        check({tag, "_kp"},     {29'd0, kp_o},        32'h6);
        check({tag, "_ki"},     {28'd0, ki_o},        32'h4);
    endtask

    initial begin
        #2 reset_i = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #3 reset_i = 1'b1;

        // Start, then 16 strobes of +3 move ACQUIRE -> TRACK.
        @(posedge clk);
        #2;
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0));
        start_i = 1'b1;
        drain("start_to_acquire");
        run(15, 8'sd3);
        check_state("acq_after_15", 2'd1);
        exp_q.push_back(mk(2'd2, 1'b1, 1'b0));
        do_strobe(8'sd3, 1'b0);
        drain("acq_to_track");

        // TRACK: a +5 in the run restarts the count; window edges +-4 are good.
        run(15, -8'sd4);
        do_strobe(8'sd5, 1'b0);
        run(15, 8'sd4);
        check_state("track_after_restart_15", 2'd2);
        exp_q.push_back(mk(2'd3, 1'b1, 1'b0));
        do_strobe(8'sd0, 1'b0);
        drain("track_to_locked");

        // LOCKED: error=16 is not bad and breaks the bad run.
        run(3, -8'sd17);
        do_strobe(8'sd16, 1'b0);
        run(3, -8'sd17);
        check_state("locked_after_bad_break", 2'd3);
        exp_q.push_back(mk(2'd1, 1'b1, 1'b1));
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0));
        do_strobe(-8'sd17, 1'b0);
        drain("lock_lost_pulse");

        // ACQUIRE: 8'h80 must count as bad, not wrap into the good window.
        run(15, 8'sd3);
        do_strobe(-8'sd128, 1'b0);
        run(15, 8'sd3);
        check_state("acq_after_min_code", 2'd1);
        exp_q.push_back(mk(2'd2, 1'b1, 1'b0));
        do_strobe(8'sd3, 1'b0);
        drain("min_code_then_track");

        // TRACK: start_i dropped on the 16th good strobe wins over the gear change.
        run(15, 8'sd2);
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0));
        do_strobe(8'sd2, 1'b1);
        drain("stop_beats_gear");
        check_state("idle_after_stop", 2'd0);

        // Climb back to LOCKED, then reset asynchronously with a sample pending.
        @(posedge clk);
        #2;
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0));
        exp_q.push_back(mk(2'd2, 1'b1, 1'b0));
        exp_q.push_back(mk(2'd3, 1'b1, 1'b0));
        start_i = 1'b1;
        run(32, 8'sd1);
        drain("relock");
        @(posedge clk);
        #2 sample_i = 1'b1;
        @(posedge clk);
        #3;
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0));
        reset_i = 1'b0;
        #1 check_reset_outputs("async_rst");
        sample_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0));
        reset_i = 1'b1;
        drain("reset_then_acquire");
        run(15, 8'sd3);
        check_state("restart_needs_full_run", 2'd1);
        exp_q.push_back(mk(2'd2, 1'b1, 1'b0));
        do_strobe(8'sd3, 1'b0);
        drain("restart_track");

        repeat (5) @(posedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
